tl_ad_buffer: RTL and testbench

TileLink-UL A/D channel buffer with an outstanding-transaction limiter. It sits directly upstream of the memory-side width widget and registers the A request path and the D response path, breaking the timing path between the crossbar and the widget. It also caps the number of in-flight transactions so downstream slaves cannot be over-subscribed. Field widths match the widget's inner port: 64-bit data, 32-bit address, 4-bit source.

---
 rtl/tl_ad_buffer.sv | 224 ++++++++++++++++++++++
 tb/tb_tl_ad_buffer.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tl_ad_buffer.sv
// tl_ad_buffer: registered TileLink-UL A/D channel buffer with an
// outstanding-transaction limiter, placed in front of the memory-side width
// widget.
//
// Ports:
//   clock, reset                   clock and synchronous active-low reset
//   auto_in_a_*                    upstream A request (valid/ready + bits)
//   auto_out_a_*                   downstream A request, from A queue head
//   auto_out_d_*                   downstream D response (valid/ready + bits)
//   auto_in_d_*                    upstream D response, from D queue head
//
// Build option: define TL_AD_BUFFER_FLOW_EN for 0-cycle pass-through when a
// queue is empty; undefined gives a strict 1-cycle registered path.

// FIFO queue: ready is a function of registered occupancy only.
module tl_ad_buffer_queue #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enq_valid,
  output logic             enq_ready,
  input  logic [WIDTH-1:0] enq_bits,
  output logic             deq_valid,
  input  logic             deq_ready,
  output logic [WIDTH-1:0] deq_bits
);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic             empty, full, enq_fire, deq_fire, push, pop;

  assign empty     = (count == '0);
  assign full      = (count == CW'(DEPTH));
  assign enq_ready = reset && !full;
  assign enq_fire  = enq_valid && enq_ready;
  assign deq_fire  = deq_valid && deq_ready;

`ifdef TL_AD_BUFFER_FLOW_EN
  // Empty queue forwards the incoming beat; it is stored only if not consumed.
  assign deq_valid = !empty || enq_fire;
  assign deq_bits  = empty ? enq_bits : mem[rd_ptr];
  assign push      = enq_fire && !(empty && deq_fire);
  assign pop       = deq_fire && !empty;
`else
  assign deq_valid = !empty;
  assign deq_bits  = mem[rd_ptr];
  assign push      = enq_fire;
  assign pop       = deq_fire;
`endif

  // Pointers and occupancy.
  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
      if (pop)  rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (!push && pop) count <= count - CW'(1);
    end
  end

  // Payload storage; contents are don't-care while empty.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= enq_bits;
  end
endmodule

module tl_ad_buffer #(
  parameter int unsigned A_DEPTH      = 2,
  parameter int unsigned D_DEPTH      = 2,
  parameter int unsigned MAX_INFLIGHT = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        auto_in_a_valid,
  output logic        auto_in_a_ready,
  input  logic [2:0]  auto_in_a_bits_opcode,
  input  logic [2:0]  auto_in_a_bits_param,
  input  logic [2:0]  auto_in_a_bits_size,
  input  logic [3:0]  auto_in_a_bits_source,
  input  logic [31:0] auto_in_a_bits_address,
  input  logic [7:0]  auto_in_a_bits_mask,
  input  logic [63:0] auto_in_a_bits_data,
  input  logic        auto_in_a_bits_corrupt,
  output logic        auto_out_a_valid,
  input  logic        auto_out_a_ready,
  output logic [2:0]  auto_out_a_bits_opcode,
  output logic [2:0]  auto_out_a_bits_param,
  output logic [2:0]  auto_out_a_bits_size,
  output logic [3:0]  auto_out_a_bits_source,
  output logic [31:0] auto_out_a_bits_address,
  output logic [7:0]  auto_out_a_bits_mask,
  output logic [63:0] auto_out_a_bits_data,
  output logic        auto_out_a_bits_corrupt,
  input  logic        auto_out_d_valid,
  output logic        auto_out_d_ready,
  input  logic [2:0]  auto_out_d_bits_opcode,
  input  logic [2:0]  auto_out_d_bits_size,
  input  logic [3:0]  auto_out_d_bits_source,
  input  logic        auto_out_d_bits_denied,
  input  logic [63:0] auto_out_d_bits_data,
  input  logic        auto_out_d_bits_corrupt,
  output logic        auto_in_d_valid,
  input  logic        auto_in_d_ready,
  output logic [2:0]  auto_in_d_bits_opcode,
  output logic [2:0]  auto_in_d_bits_size,
  output logic [3:0]  auto_in_d_bits_source,
  output logic        auto_in_d_bits_denied,
  output logic [63:0] auto_in_d_bits_data,
  output logic        auto_in_d_bits_corrupt
);
  typedef struct packed {
    logic [2:0]  opcode;
    logic [2:0]  param;
    logic [2:0]  size;
    logic [3:0]  source;
    logic [31:0] address;
    logic [7:0]  mask;
    logic [63:0] data;
    logic        corrupt;
  } a_beat_t;

  typedef struct packed {
    logic [2:0]  opcode;
    logic [2:0]  size;
    logic [3:0]  source;
    logic        denied;
    logic [63:0] data;
    logic        corrupt;
  } d_beat_t;

  // Index of the last beat of a message: beats(size) - 1, 0 for dataless ops.
  function automatic logic [3:0] last_idx(input logic has_data, input logic [2:0] size);
    if (!has_data || size <= 3'd3) return 4'd0;
    return 4'((5'd1 << (size - 3'd3)) - 5'd1);
  endfunction

  a_beat_t a_enq, a_deq;
  d_beat_t d_enq, d_deq;
  logic    a_q_ready, a_q_enq_valid, limit_block;
  logic    a_fire, d_fire, a_first, a_last, d_last, inc, dec;
  logic [3:0] a_beat, d_beat, inflight;

  // The limiter only gates the first beat, so a started burst always completes.
  assign limit_block     = (a_beat == 4'd0) && (inflight == 4'(MAX_INFLIGHT));
  assign a_q_enq_valid   = auto_in_a_valid && !limit_block;
  assign auto_in_a_ready = a_q_ready && !limit_block;

  assign a_fire  = auto_in_a_valid && auto_in_a_ready;
  assign d_fire  = auto_in_d_valid && auto_in_d_ready;
  assign a_first = (a_beat == 4'd0);
  assign a_last  = (a_beat == last_idx(!auto_in_a_bits_opcode[2], auto_in_a_bits_size));
  assign d_last  = (d_beat == last_idx(auto_in_d_bits_opcode == 3'd1, auto_in_d_bits_size));
  assign inc     = a_fire && a_first;
  assign dec     = d_fire && d_last;

  assign a_enq = '{opcode: auto_in_a_bits_opcode, param: auto_in_a_bits_param,
                   size: auto_in_a_bits_size, source: auto_in_a_bits_source,
                   address: auto_in_a_bits_address, mask: auto_in_a_bits_mask,
                   data: auto_in_a_bits_data, corrupt: auto_in_a_bits_corrupt};
  assign d_enq = '{opcode: auto_out_d_bits_opcode, size: auto_out_d_bits_size,
                   source: auto_out_d_bits_source, denied: auto_out_d_bits_denied,
                   data: auto_out_d_bits_data, corrupt: auto_out_d_bits_corrupt};

  tl_ad_buffer_queue #(.DEPTH(A_DEPTH), .WIDTH($bits(a_beat_t))) u_a_queue (
    .clock     (clock),
    .reset     (reset),
    .enq_valid (a_q_enq_valid),
    .enq_ready (a_q_ready),
    .enq_bits  (a_enq),
    .deq_valid (auto_out_a_valid),
    .deq_ready (auto_out_a_ready),
    .deq_bits  (a_deq)
  );

  tl_ad_buffer_queue #(.DEPTH(D_DEPTH), .WIDTH($bits(d_beat_t))) u_d_queue (
    .clock     (clock),
    .reset     (reset),
    .enq_valid (auto_out_d_valid),
    .enq_ready (auto_out_d_ready),
    .enq_bits  (d_enq),
    .deq_valid (auto_in_d_valid),
    .deq_ready (auto_in_d_ready),
    .deq_bits  (d_deq)
  );

  assign auto_out_a_bits_opcode  = a_deq.opcode;
  assign auto_out_a_bits_param   = a_deq.param;
  assign auto_out_a_bits_size    = a_deq.size;
  assign auto_out_a_bits_source  = a_deq.source;
  assign auto_out_a_bits_address = a_deq.address;
  assign auto_out_a_bits_mask    = a_deq.mask;
  assign auto_out_a_bits_data    = a_deq.data;
  assign auto_out_a_bits_corrupt = a_deq.corrupt;

  assign auto_in_d_bits_opcode  = d_deq.opcode;
  assign auto_in_d_bits_size    = d_deq.size;
  assign auto_in_d_bits_source  = d_deq.source;
  assign auto_in_d_bits_denied  = d_deq.denied;
  assign auto_in_d_bits_data    = d_deq.data;
  assign auto_in_d_bits_corrupt = d_deq.corrupt;

  // Beat tracking and in-flight accounting.
  always_ff @(posedge clock) begin
    if (!reset) begin
      a_beat   <= 4'd0;
      d_beat   <= 4'd0;
      inflight <= 4'd0;
    end else begin
      if (a_fire) a_beat <= a_last ? 4'd0 : a_beat + 4'd1;
      if (d_fire) d_beat <= d_last ? 4'd0 : d_beat + 4'd1;
      if (inc && !dec)      inflight <= inflight + 4'd1;
      else if (!inc && dec) inflight <= inflight - 4'd1;
    end
  end
endmodule

// File: tb/tb_tl_ad_buffer.sv
// Directed bench for tl_ad_buffer (default build, MAX_INFLIGHT=2).
module tb_tl_ad_buffer;
  logic        clock = 1'b0;
  logic        reset;
  logic        in_a_valid, in_a_ready;
  logic [2:0]  in_a_opcode, in_a_param, in_a_size;
  logic [3:0]  in_a_source;
  logic [31:0] in_a_address;
  logic [7:0]  in_a_mask;
  logic [63:0] in_a_data;
  logic        in_a_corrupt;
  logic        out_a_valid, out_a_ready;
  logic [2:0]  out_a_opcode, out_a_param, out_a_size;
  logic [3:0]  out_a_source;
  logic [31:0] out_a_address;
  logic [7:0]  out_a_mask;
  logic [63:0] out_a_data;
  logic        out_a_corrupt;
  logic        out_d_valid, out_d_ready;
  logic [2:0]  out_d_opcode, out_d_size;
  logic [3:0]  out_d_source;
  logic        out_d_denied;
  logic [63:0] out_d_data;
  logic        out_d_corrupt;
  logic        in_d_valid, in_d_ready;
  logic [2:0]  in_d_opcode, in_d_size;
  logic [3:0]  in_d_source;
  logic        in_d_denied;
  logic [63:0] in_d_data;
  logic        in_d_corrupt;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  tl_ad_buffer #(.A_DEPTH(2), .D_DEPTH(2), .MAX_INFLIGHT(2)) dut (
    .clock                   (clock),
    .reset                   (reset),
    .auto_in_a_valid         (in_a_valid),
    .auto_in_a_ready         (in_a_ready),
    .auto_in_a_bits_opcode   (in_a_opcode),
    .auto_in_a_bits_param    (in_a_param),
    .auto_in_a_bits_size     (in_a_size),
    .auto_in_a_bits_source   (in_a_source),
    .auto_in_a_bits_address  (in_a_address),
    .auto_in_a_bits_mask     (in_a_mask),
    .auto_in_a_bits_data     (in_a_data),
    .auto_in_a_bits_corrupt  (in_a_corrupt),
    .auto_out_a_valid        (out_a_valid),
    .auto_out_a_ready        (out_a_ready),
    .auto_out_a_bits_opcode  (out_a_opcode),
    .auto_out_a_bits_param   (out_a_param),
    .auto_out_a_bits_size    (out_a_size),
    .auto_out_a_bits_source  (out_a_source),
    .auto_out_a_bits_address (out_a_address),
    .auto_out_a_bits_mask    (out_a_mask),
    .auto_out_a_bits_data    (out_a_data),
    .auto_out_a_bits_corrupt (out_a_corrupt),
    .auto_out_d_valid        (out_d_valid),
    .auto_out_d_ready        (out_d_ready),
    .auto_out_d_bits_opcode  (out_d_opcode),
    .auto_out_d_bits_size    (out_d_size),
    .auto_out_d_bits_source  (out_d_source),
    .auto_out_d_bits_denied  (out_d_denied),
    .auto_out_d_bits_data    (out_d_data),
    .auto_out_d_bits_corrupt (out_d_corrupt),
    .auto_in_d_valid         (in_d_valid),
    .auto_in_d_ready         (in_d_ready),
    .auto_in_d_bits_opcode   (in_d_opcode),
    .auto_in_d_bits_size     (in_d_size),
    .auto_in_d_bits_source   (in_d_source),
    .auto_in_d_bits_denied   (in_d_denied),
    .auto_in_d_bits_data     (in_d_data),
    .auto_in_d_bits_corrupt  (in_d_corrupt)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic set_a(input logic v, input logic [2:0] op, input logic [2:0] sz,
                       input logic [3:0] src, input logic [31:0] addr, input logic [63:0] dat);
    in_a_valid   = v;
    in_a_opcode  = op;
    in_a_param   = 3'd0;
    in_a_size    = sz;
    in_a_source  = src;
    in_a_address = addr;
    in_a_mask    = 8'hff;
    in_a_data    = dat;
    in_a_corrupt = 1'b0;
  endtask

  task automatic set_d(input logic v, input logic [2:0] op, input logic [2:0] sz,
                       input logic [3:0] src, input logic [63:0] dat);
    out_d_valid   = v;
    out_d_opcode  = op;
    out_d_size    = sz;
    out_d_source  = src;
    out_d_denied  = 1'b0;
    out_d_data    = dat;
    out_d_corrupt = 1'b0;
  endtask

  initial begin
    int m, nin, nout;
    logic saw_stall;

    // Reset held low for two edges.
    reset = 1'b0;
    out_a_ready = 1'b0;
    in_d_ready  = 1'b0;
    set_a(1'b0, 3'd0, 3'd0, 4'd0, 32'd0, 64'd0);
    set_d(1'b0, 3'd0, 3'd0, 4'd0, 64'd0);
    cyc();
    cyc();
    #2;
    chk("rst_in_a_ready", 128'(in_a_ready), 128'(0));
    chk("rst_out_d_ready", 128'(out_d_ready), 128'(0));
    chk("rst_out_a_valid", 128'(out_a_valid), 128'(0));
    chk("rst_in_d_valid", 128'(in_d_valid), 128'(0));

    // Release.
    cyc();
    reset = 1'b1;
    out_a_ready = 1'b1;
    in_d_ready  = 1'b1;
    #2;
    chk("rel_in_a_ready", 128'(in_a_ready), 128'(1));
    chk("rel_out_d_ready", 128'(out_d_ready), 128'(1));
    chk("rel_out_a_valid", 128'(out_a_valid), 128'(0));
    chk("rel_inflight", 128'(dut.inflight), 128'(0));

    // Single Get and its AccessAckData.
    cyc();
    set_a(1'b1, 3'd4, 3'd3, 4'd5, 32'h8000_0000, 64'd0);
    #2;
    chk("get_in_ready", 128'(in_a_ready), 128'(1));
    chk("get_out_valid_c0", 128'(out_a_valid), 128'(0));
    cyc();
    set_a(1'b0, 3'd0, 3'd0, 4'd0, 32'd0, 64'd0);
    #2;
    chk("get_out_valid_c1", 128'(out_a_valid), 128'(1));
    chk("get_out_opcode", 128'(out_a_opcode), 128'(4));
    chk("get_out_size", 128'(out_a_size), 128'(3));
    chk("get_out_source", 128'(out_a_source), 128'(5));
    chk("get_out_address", 128'(out_a_address), 128'(32'h8000_0000));
    chk("get_out_mask", 128'(out_a_mask), 128'(8'hff));
    chk("get_inflight_1", 128'(dut.inflight), 128'(1));
    cyc();
    set_d(1'b1, 3'd1, 3'd3, 4'd5, 64'hdead_beef_0123_4567);
    #2;
    chk("get_out_valid_c2", 128'(out_a_valid), 128'(0));
    chk("ackd_in_valid_c0", 128'(in_d_valid), 128'(0));
    cyc();
    set_d(1'b0, 3'd0, 3'd0, 4'd0, 64'd0);
    #2;
    chk("ackd_in_valid_c1", 128'(in_d_valid), 128'(1));
    chk("ackd_opcode", 128'(in_d_opcode), 128'(1));
    chk("ackd_source", 128'(in_d_source), 128'(5));
    chk("ackd_data", 128'(in_d_data), 128'(64'hdead_beef_0123_4567));
    cyc();
    #2;
    chk("ackd_in_valid_c2", 128'(in_d_valid), 128'(0));
    chk("ackd_inflight_0", 128'(dut.inflight), 128'(0));

    // PutFull, size 6 = 8 beats, back to back.
    for (int k = 0; k <= 9; k++) begin
      cyc();
      if (k < 8) set_a(1'b1, 3'd0, 3'd6, 4'd2, 32'h1000, 64'(k));
      else       set_a(1'b0, 3'd0, 3'd0, 4'd0, 32'd0, 64'd0);
      #2;
      if (k < 8) chk($sformatf("put_in_ready_%0d", k), 128'(in_a_ready), 128'(1));
      chk($sformatf("put_out_valid_%0d", k), 128'(out_a_valid), 128'(k >= 1 && k <= 8));
      if (k >= 1 && k <= 8)
        chk($sformatf("put_out_data_%0d", k), 128'(out_a_data), 128'(k - 1));
    end
    chk("put_inflight_1", 128'(dut.inflight), 128'(1));
    // AccessAck without data: one beat clears the put.
    cyc();
    set_d(1'b1, 3'd0, 3'd6, 4'd2, 64'd0);
    cyc();
    set_d(1'b0, 3'd0, 3'd0, 4'd0, 64'd0);
    cyc();
    #2;
    chk("put_inflight_0", 128'(dut.inflight), 128'(0));

    // Limiter with MAX_INFLIGHT=2.
    cyc();
    set_a(1'b1, 3'd4, 3'd3, 4'd1, 32'h100, 64'd0);
    #2;
    chk("lim_ready_1", 128'(in_a_ready), 128'(1));
    cyc();
    set_a(1'b1, 3'd4, 3'd3, 4'd2, 32'h200, 64'd0);
    #2;
    chk("lim_ready_2", 128'(in_a_ready), 128'(1));
    cyc();
    set_a(1'b1, 3'd4, 3'd3, 4'd3, 32'h300, 64'd0);
    #2;
    chk("lim_ready_3_stall", 128'(in_a_ready), 128'(0));
    chk("lim_out_src2", 128'(out_a_source), 128'(2));
    cyc();
    set_d(1'b1, 3'd1, 3'd3, 4'd1, 64'h11);
    #2;
    chk("lim_still_stall", 128'(in_a_ready), 128'(0));
    cyc();
    set_d(1'b0, 3'd0, 3'd0, 4'd0, 64'd0);
    #2;
    chk("lim_stall_d_pending", 128'(in_a_ready), 128'(0));
    chk("lim_d_src1", 128'(in_d_source), 128'(1));
    cyc();
    #2;
    chk("lim_release", 128'(in_a_ready), 128'(1));
    cyc();
    set_a(1'b0, 3'd0, 3'd0, 4'd0, 32'd0, 64'd0);
    #2;
    chk("lim_out_valid3", 128'(out_a_valid), 128'(1));
    chk("lim_out_src3", 128'(out_a_source), 128'(3));
    chk("lim_inflight_2", 128'(dut.inflight), 128'(2));
    cyc();
    set_d(1'b1, 3'd1, 3'd3, 4'd2, 64'h22);
    cyc();
    set_d(1'b1, 3'd1, 3'd3, 4'd3, 64'h33);
    cyc();
    set_d(1'b0, 3'd0, 3'd0, 4'd0, 64'd0);
    cyc();
    cyc();
    #2;
    chk("lim_inflight_0", 128'(dut.inflight), 128'(0));

    // Backpressure: out_a_ready low for 5 cycles under a continuous 8-beat Put.
    m = 0; nin = 0; nout = 0; saw_stall = 1'b0;
    for (int c = 0; c < 40 && nout < 8; c++) begin
      cyc();
      if (nin < 8) set_a(1'b1, 3'd0, 3'd6, 4'd7, 32'h2000, 64'(100 + nin));
      else         set_a(1'b0, 3'd0, 3'd0, 4'd0, 32'd0, 64'd0);
      out_a_ready = (c >= 5);
      #2;
      if (nin < 8) begin
        chk($sformatf("bp_in_ready_%0d", c), 128'(in_a_ready), 128'(m < 2));
        if (m >= 2) saw_stall = 1'b1;
      end
      chk($sformatf("bp_out_valid_%0d", c), 128'(out_a_valid), 128'(m > 0));
      if (m > 0) chk($sformatf("bp_out_data_%0d", c), 128'(out_a_data), 128'(100 + nout));
      begin
        int ef, df;
        ef = (nin < 8 && m < 2) ? 1 : 0;
        df = (m > 0 && c >= 5) ? 1 : 0;
        m = m + ef - df;
        nin += ef;
        nout += df;
      end
    end
    chk("bp_all_out", 128'(nout), 128'(8));
    chk("bp_saw_stall", 128'(saw_stall), 128'(1));
    chk("bp_inflight_1", 128'(dut.inflight), 128'(1));
    cyc();
    set_a(1'b0, 3'd0, 3'd0, 4'd0, 32'd0, 64'd0);
    set_d(1'b1, 3'd0, 3'd6, 4'd7, 64'd0);
    cyc();
    set_d(1'b0, 3'd0, 3'd0, 4'd0, 64'd0);
    cyc();
    #2;
    chk("bp_inflight_0", 128'(dut.inflight), 128'(0));

    // Reset mid-burst with both queues holding beats.
    out_a_ready = 1'b0;
    in_d_ready  = 1'b0;
    for (int k = 0; k < 2; k++) begin
      cyc();
      set_a(1'b1, 3'd0, 3'd6, 4'd9, 32'h3000, 64'(k));
      set_d(1'b1, 3'd1, 3'd3, 4'd9, 64'(k));
    end
    cyc();
    #2;
    chk("mr_out_a_valid_pre", 128'(out_a_valid), 128'(1));
    chk("mr_in_d_valid_pre", 128'(in_d_valid), 128'(1));
    reset = 1'b0;
    #1;
    chk("mr_in_a_ready_rst", 128'(in_a_ready), 128'(0));
    chk("mr_out_d_ready_rst", 128'(out_d_ready), 128'(0));
    cyc();
    set_a(1'b0, 3'd0, 3'd0, 4'd0, 32'd0, 64'd0);
    set_d(1'b0, 3'd0, 3'd0, 4'd0, 64'd0);
    #2;
    chk("mr_out_a_valid", 128'(out_a_valid), 128'(0));
    chk("mr_in_d_valid", 128'(in_d_valid), 128'(0));
    chk("mr_inflight", 128'(dut.inflight), 128'(0));
    chk("mr_a_beat", 128'(dut.a_beat), 128'(0));
    cyc();
    reset = 1'b1;
    out_a_ready = 1'b1;
    in_d_ready  = 1'b1;
    #2;
    chk("mr_rel_in_a_ready", 128'(in_a_ready), 128'(1));
    chk("mr_rel_out_d_ready", 128'(out_d_ready), 128'(1));
    chk("mr_rel_out_a_valid", 128'(out_a_valid), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
